// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI request arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } t_arb_state;

  localparam int REQ_DCACHE = 0;
  localparam int REQ_ICACHE = 1;
  localparam int NUM_REQ    = 2;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the D-cache and I-cache requesters.
module arb_pick
  import axi_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] pending,
  input  logic               rr_last,
  input  logic               rr_mode,
  output logic [NUM_REQ-1:0] winner
);

  // On contention the requester not served last wins in round-robin mode;
  // otherwise the D-cache always wins.
  always_comb begin
    winner = '0;
    if (pending[REQ_DCACHE] && pending[REQ_ICACHE]) begin
      if (rr_mode && !rr_last) winner[REQ_ICACHE] = 1'b1;
      else                     winner[REQ_DCACHE] = 1'b1;
    end else begin
      winner = pending;
    end
  end

endmodule

// File: rtl/axi_req_arbiter.sv
// Shares one AXI4 master between the D-cache (port 0) and I-cache (port 1).
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module axi_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [1:0]                    i_req_wr,
  input  logic [1:0]                    i_req_rd,
  input  logic [1:0][ADDR_W-1:0]        i_req_addr,
  input  logic [1:0][DATA_W-1:0]        i_req_wdata,
  input  logic [1:0][LEN_W-1:0]         i_req_len,
  input  logic [1:0][2:0]               i_req_size,
  input  logic [1:0][1:0]               i_req_burst,
  input  logic [1:0][DATA_W/8-1:0]      i_req_strb,
  output logic [DATA_W-1:0]             o_req_rdata,
  output logic [1:0]                    o_req_handshake,
  output logic [1:0]                    o_req_done,
  output logic [1:0]                    o_grant,
  output logic                          o_m_write_req,
  output logic                          o_m_read_req,
  output logic [ADDR_W-1:0]             o_m_addr,
  output logic [DATA_W-1:0]             o_m_wdata,
  output logic [LEN_W-1:0]              o_m_len,
  output logic [2:0]                    o_m_size,
  output logic [1:0]                    o_m_burst,
  output logic [DATA_W/8-1:0]           o_m_strb,
  input  logic [DATA_W-1:0]             i_m_rdata,
  input  logic                          i_m_handshake,
  input  logic                          i_m_done
);

  t_arb_state         state, state_nxt;
  logic [NUM_REQ-1:0] grant, grant_nxt;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] winner;
  logic               owner;
  logic               rr_last;
  logic               rr_mode;

  assign pending = i_req_wr | i_req_rd;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  assign rr_mode = 1'b1;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)             rr_last <= 1'b1;
    else if (state == ISSUE) rr_last <= grant[REQ_ICACHE];
  end
`else
  assign rr_mode = 1'b0;
  assign rr_last = 1'b1;
`endif

  arb_pick u_pick (
    .pending (pending),
    .rr_last (rr_last),
    .rr_mode (rr_mode),
    .winner  (winner)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ARB;
      grant <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // Master requests are raised only in the single ISSUE cycle, so a request
  // can never be seen by the master while a transaction is in flight.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    o_m_write_req = 1'b0;
    o_m_read_req  = 1'b0;
    case (state)
      ARB: begin
        if (|pending) begin
          grant_nxt = winner;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if ((i_req_wr & grant) != '0) o_m_write_req = 1'b1;
        else                          o_m_read_req  = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (i_m_done) begin
          grant_nxt = '0;
          state_nxt = ARB;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ARB;
      end
    endcase
  end

  assign owner = grant[REQ_ICACHE];

  always_comb begin
    o_m_addr  = '0;
    o_m_wdata = '0;
    o_m_len   = '0;
    o_m_size  = '0;
    o_m_burst = '0;
    o_m_strb  = '0;
    if (grant != '0) begin
      o_m_addr  = i_req_addr[owner];
      o_m_wdata = i_req_wdata[owner];
      o_m_len   = i_req_len[owner];
      o_m_size  = i_req_size[owner];
      o_m_burst = i_req_burst[owner];
      o_m_strb  = i_req_strb[owner];
    end
  end

  assign o_grant         = grant;
  assign o_req_rdata     = i_m_rdata;
  assign o_req_handshake = {NUM_REQ{i_m_handshake}} & grant;
  assign o_req_done      = {NUM_REQ{i_m_done}} & grant;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Self-checking bench for axi_req_arbiter: cycle model plus directed scenarios.
module tb_axi_req_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 8;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [63:0] WB = 64'hA5A5_0000_0000_0000;

  logic                     clk = 1'b0;
  logic                     arst_n = 1'b0;
  logic [1:0]               req_wr, req_rd;
  logic [1:0][ADDR_W-1:0]   req_addr;
  logic [1:0][DATA_W-1:0]   req_wdata;
  logic [1:0][LEN_W-1:0]    req_len;
  logic [1:0][2:0]          req_size;
  logic [1:0][1:0]          req_burst;
  logic [1:0][STRB_W-1:0]   req_strb;
  logic [DATA_W-1:0]        o_req_rdata;
  logic [1:0]               o_req_handshake, o_req_done, o_grant;
  logic                     o_m_write_req, o_m_read_req;
  logic [ADDR_W-1:0]        o_m_addr;
  logic [DATA_W-1:0]        o_m_wdata;
  logic [LEN_W-1:0]         o_m_len;
  logic [2:0]               o_m_size;
  logic [1:0]               o_m_burst;
  logic [STRB_W-1:0]        o_m_strb;
  logic [DATA_W-1:0]        i_m_rdata;
  logic                     i_m_handshake, i_m_done;

  axi_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .i_req_wr(req_wr), .i_req_rd(req_rd), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_len(req_len), .i_req_size(req_size),
    .i_req_burst(req_burst), .i_req_strb(req_strb),
    .o_req_rdata(o_req_rdata), .o_req_handshake(o_req_handshake),
    .o_req_done(o_req_done), .o_grant(o_grant),
    .o_m_write_req(o_m_write_req), .o_m_read_req(o_m_read_req),
    .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata), .o_m_len(o_m_len),
    .o_m_size(o_m_size), .o_m_burst(o_m_burst), .o_m_strb(o_m_strb),
    .i_m_rdata(i_m_rdata), .i_m_handshake(i_m_handshake), .i_m_done(i_m_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: who owns the master, whether this is the owner's first cycle, last served.
  int md_owner = -1;
  bit md_fresh = 1'b0;
  int md_last  = 1;

  // Environment: requester transaction budgets and master responder state.
  int rem_wr[2];
  int rem_rd[2];
  int m_beats = 0;
  bit m_done_due = 1'b0;
  int cyc = 0;

  // Observations collected by the compare process.
  bit          s_issue = 1'b0;
  logic [7:0]  s_len = '0;
  bit          s_done[2];
  bit          s_wr_issued[2];
  int          beat0 = 0;
  int          hs_cnt[2];
  int          done_cnt[2];
  typedef struct {int port; bit wr; logic [31:0] addr; logic [7:0] len;} iss_t;
  iss_t        log_q[$];
  int          done_q[$];
  logic [63:0] wd_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] p, input int last);
    if (p == 2'b11) begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
      return 1 - last;
`else
      return (last < 0) ? 1 : 0;
`endif
    end
    return p[0] ? 0 : 1;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      md_owner <= -1;
      md_fresh <= 1'b0;
      md_last  <= 1;
    end else if (md_owner < 0) begin
      if ((req_wr | req_rd) != 2'b00) begin
        md_owner <= pick(req_wr | req_rd, md_last);
        md_fresh <= 1'b1;
      end
    end else if (md_fresh) begin
      md_fresh <= 1'b0;
      md_last  <= md_owner;
    end else if (i_m_done) begin
      md_owner <= -1;
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      s_done[k] = 1'b0; s_wr_issued[k] = 1'b0; hs_cnt[k] = 0; done_cnt[k] = 0;
    end
    forever begin
      logic [1:0]        eg;
      logic              ew, er;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed;
      logic [LEN_W-1:0]  el;
      logic [2:0]        es;
      logic [1:0]        eb;
      logic [STRB_W-1:0] est;
      @(negedge clk);
      s_issue = o_m_read_req | o_m_write_req;
      s_len   = o_m_len;
      for (int k = 0; k < 2; k++) begin
        s_done[k] = o_req_done[k];
        if (o_req_done[k]) begin done_cnt[k]++; done_q.push_back(k); end
        if (o_req_handshake[k]) hs_cnt[k]++;
        if (o_grant[k] && o_m_write_req) s_wr_issued[k] = 1'b1;
        if (o_grant[k] && o_m_read_req)  s_wr_issued[k] = 1'b0;
      end
      if (o_req_handshake[0]) begin wd_q.push_back(o_m_wdata); beat0++; end
      if (s_issue) begin
        beat0 = 0;
        log_q.push_back('{o_grant[1] ? 1 : 0, o_m_write_req, o_m_addr, o_m_len});
      end
      if (chk_en) begin
        eg = 2'b00; ew = 1'b0; er = 1'b0;
        ea = '0; ed = '0; el = '0; es = '0; eb = '0; est = '0;
        if (md_owner >= 0) begin
          eg[md_owner] = 1'b1;
          ew  = md_fresh && req_wr[md_owner];
          er  = md_fresh && !req_wr[md_owner];
          ea  = req_addr[md_owner];
          ed  = req_wdata[md_owner];
          el  = req_len[md_owner];
          es  = req_size[md_owner];
          eb  = req_burst[md_owner];
          est = req_strb[md_owner];
        end
        chk("grant",     64'(o_grant), 64'(eg));
        chk("m_wr_req",  64'(o_m_write_req), 64'(ew));
        chk("m_rd_req",  64'(o_m_read_req), 64'(er));
        chk("m_addr",    64'(o_m_addr), 64'(ea));
        chk("m_wdata",   o_m_wdata, ed);
        chk("m_len",     64'(o_m_len), 64'(el));
        chk("m_size",    64'(o_m_size), 64'(es));
        chk("m_burst",   64'(o_m_burst), 64'(eb));
        chk("m_strb",    64'(o_m_strb), 64'(est));
        chk("handshake", 64'(o_req_handshake), 64'({2{i_m_handshake}} & eg));
        chk("done",      64'(o_req_done), 64'({2{i_m_done}} & eg));
        chk("rdata",     o_req_rdata, i_m_rdata);
      end
    end
  end

  // One clock of environment: cache requesters and a simple master responder.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (s_done[k]) begin
        if (s_wr_issued[k]) rem_wr[k]--;
        else                rem_rd[k]--;
      end
      req_wr[k] = (rem_wr[k] > 0);
      req_rd[k] = (rem_rd[k] > 0);
    end
    req_wdata[0] = WB + 64'(beat0);
    i_m_rdata = {32'hD00D_0000, 32'(cyc)};
    i_m_handshake = 1'b0;
    i_m_done = 1'b0;
    if (!arst_n) begin
      m_beats = 0; m_done_due = 1'b0;
    end else if (s_issue) begin
      m_beats = int'(s_len) + 1; m_done_due = 1'b0;
    end else if (m_beats > 0) begin
      i_m_handshake = 1'b1;
      m_beats--;
      if (m_beats == 0) m_done_due = 1'b1;
    end else if (m_done_due) begin
      i_m_done = 1'b1;
      m_done_due = 1'b0;
    end
  endtask

  task automatic run_until_idle(input string nm, input int budget);
    int n = 0;
    while (!(rem_wr[0] == 0 && rem_wr[1] == 0 && rem_rd[0] == 0 && rem_rd[1] == 0 &&
             md_owner < 0 && m_beats == 0 && !m_done_due) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, required idle", nm, n);
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    i_m_handshake = 1'b0; i_m_done = 1'b0;
    m_beats = 0; m_done_due = 1'b0;
    for (int k = 0; k < 2; k++) begin rem_wr[k] = 0; rem_rd[k] = 0; end
    step(); step();
    chk("rst_grant", 64'(o_grant), 64'd0);
    chk("rst_reqs",  64'({o_m_write_req, o_m_read_req}), 64'd0);
    arst_n = 1'b1;
    step();
  endtask

  task automatic set_attr(input int k, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b, input logic [7:0] st,
                          input logic [63:0] wd);
    req_addr[k] = a; req_len[k] = l; req_size[k] = s; req_burst[k] = b;
    req_strb[k] = st; req_wdata[k] = wd;
  endtask

  task automatic chk_log(input string nm, input int idx, input int port, input bit wr);
    if (idx < log_q.size()) begin
      chk({nm, "_port"}, 64'(log_q[idx].port), 64'(port));
      chk({nm, "_wr"},   64'(log_q[idx].wr), 64'(wr));
    end else begin
      checks++; errors++;
      $display("FAIL %s: issue %0d missing, only %0d issued", nm, idx, log_q.size());
    end
  endtask

  initial begin
    int b0, b1, d0, d1, lb, db, wb_i;
    int ord[4];
    req_wr = '0; req_rd = '0;
    i_m_handshake = 1'b0; i_m_done = 1'b0; i_m_rdata = '0;
    for (int k = 0; k < 2; k++) begin rem_wr[k] = 0; rem_rd[k] = 0; end
    set_attr(0, 32'h0, 8'd0, 3'd0, 2'd0, 8'h00, 64'd0);
    set_attr(1, 32'h0, 8'd0, 3'd0, 2'd0, 8'h00, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_grant", 64'(o_grant), 64'd0);
    chk("reset_reqs",  64'({o_m_write_req, o_m_read_req}), 64'd0);
    chk("reset_addr",  64'(o_m_addr), 64'd0);
    arst_n = 1'b1;
    step();

    // Single D-cache read burst of 8 beats.
    do_reset();
    set_attr(0, 32'h8000_0040, 8'd7, 3'd3, 2'd1, 8'hFF, 64'd0);
    set_attr(1, 32'h0000_2000, 8'd1, 3'd2, 2'd2, 8'h0F, 64'h1111_2222_3333_4444);
    lb = log_q.size(); b0 = hs_cnt[0]; b1 = hs_cnt[1]; d0 = done_cnt[0];
    rem_rd[0] = 1;
    run_until_idle("t1", 200);
    chk("t1_issues", 64'(log_q.size() - lb), 64'd1);
    chk_log("t1", lb, 0, 1'b0);
    if (log_q.size() > lb) begin
      chk("t1_addr", 64'(log_q[lb].addr), 64'h8000_0040);
      chk("t1_len",  64'(log_q[lb].len), 64'd7);
    end
    chk("t1_hs0",   64'(hs_cnt[0] - b0), 64'd8);
    chk("t1_hs1",   64'(hs_cnt[1] - b1), 64'd0);
    chk("t1_done0", 64'(done_cnt[0] - d0), 64'd1);
    chk("t1_grant_idle", 64'(o_grant), 64'd0);

    // Both requesters post two reads each in the same cycle, held until served.
    do_reset();
    lb = log_q.size();
    rem_rd[0] = 2; rem_rd[1] = 2;
    run_until_idle("t2", 400);
`ifdef AXI_ARB_ROUND_ROBIN_EN
    ord = '{0, 1, 0, 1};
`else
    ord = '{0, 0, 1, 1};
`endif
    chk("t2_issues", 64'(log_q.size() - lb), 64'd4);
    for (int i = 0; i < 4; i++) chk_log($sformatf("t2_order%0d", i), lb + i, ord[i], 1'b0);

    // D-cache write of 4 beats with an I-cache read arriving while it is busy.
    do_reset();
    set_attr(0, 32'h8000_0100, 8'd3, 3'd3, 2'd1, 8'hFF, WB);
    lb = log_q.size(); db = done_q.size(); wb_i = wd_q.size();
    b0 = hs_cnt[0]; b1 = hs_cnt[1];
    rem_wr[0] = 1;
    step(); step();
    rem_rd[1] = 1;
    run_until_idle("t3", 300);
    chk("t3_issues", 64'(log_q.size() - lb), 64'd2);
    chk_log("t3_first", lb, 0, 1'b1);
    chk_log("t3_second", lb + 1, 1, 1'b0);
    chk("t3_hs0", 64'(hs_cnt[0] - b0), 64'd4);
    chk("t3_hs1", 64'(hs_cnt[1] - b1), 64'd2);
    chk("t3_dones", 64'(done_q.size() - db), 64'd2);
    if (done_q.size() >= db + 2) begin
      chk("t3_done_first",  64'(done_q[db]), 64'd0);
      chk("t3_done_second", 64'(done_q[db + 1]), 64'd1);
    end
    chk("t3_wbeats", 64'(wd_q.size() - wb_i), 64'd4);
    for (int i = 0; i < 4; i++)
      if (wb_i + i < wd_q.size())
        chk($sformatf("t3_wdata%0d", i), wd_q[wb_i + i], WB + 64'(i));

    // Owner asks for write and read together: write first, read separately.
    do_reset();
    lb = log_q.size(); d0 = done_cnt[0];
    rem_wr[0] = 1; rem_rd[0] = 1;
    run_until_idle("t4", 300);
    chk("t4_issues", 64'(log_q.size() - lb), 64'd2);
    chk_log("t4_first", lb, 0, 1'b1);
    chk_log("t4_second", lb + 1, 0, 1'b0);
    chk("t4_done0", 64'(done_cnt[0] - d0), 64'd2);

    // Reset in the middle of an I-cache burst, then re-arbitration.
    do_reset();
    set_attr(1, 32'h0000_3000, 8'd15, 3'd3, 2'd1, 8'hFF, 64'd0);
    lb = log_q.size(); b1 = hs_cnt[1]; d1 = done_cnt[1];
    rem_rd[1] = 1;
    begin
      int n = 0;
      while ((hs_cnt[1] - b1) < 3 && n < 100) begin step(); n++; end
      checks++;
      if (n >= 100) begin
        errors++;
        $display("FAIL t5_wait: no handshakes after %0d cycles, required 3", n);
      end
    end
    arst_n = 1'b0;
    i_m_handshake = 1'b0; i_m_done = 1'b0;
    m_beats = 0; m_done_due = 1'b0;
    #1;
    chk("t5_rst_grant", 64'(o_grant), 64'd0);
    chk("t5_rst_reqs",  64'({o_m_write_req, o_m_read_req}), 64'd0);
    step();
    chk("t5_rst_grant_next", 64'(o_grant), 64'd0);
    chk("t5_rst_reqs_next",  64'({o_m_write_req, o_m_read_req}), 64'd0);
    arst_n = 1'b1;
    run_until_idle("t5", 300);
    chk("t5_issues", 64'(log_q.size() - lb), 64'd2);
    chk_log("t5_reissue", lb + 1, 1, 1'b0);
    chk("t5_hs1",   64'(hs_cnt[1] - b1), 64'd19);
    chk("t5_done1", 64'(done_cnt[1] - d1), 64'd1);

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
